collision_scheduler: RTL

- Frame-level controller that sequences all collision checks for one physics step: ball-vs-pin (10 checks), then pin-vs-pin (45 pairs, i<j).
- One check per cycle is issued into a single shared pipelined pair-check unit, instead of instantiating 55 parallel multipliers.
- Sits between the physics state registers and the motion integrator.
- Pulses done once per frame with updated pin velocities and hit flags.

---
 rtl/physics_pkg.sv | 48 ++++
 rtl/pair_check.sv | 74 +++++++
 rtl/collision_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/physics_pkg.sv
// Shared constants, state encoding and pair-tag payload for the collision scheduler.
package physics_pkg;

    localparam int unsigned NUM_PINS      = 10;
    localparam int unsigned NUM_PAIRS     = NUM_PINS * (NUM_PINS - 1) / 2;
    localparam int unsigned BALL_RADIUS   = 8;
    localparam int unsigned PIN_RADIUS    = 5;
    localparam int unsigned SCREEN_WIDTH  = 1024;
    localparam int unsigned SCREEN_HEIGHT = 768;

    localparam int unsigned POS_X_W  = 11;
    localparam int unsigned POS_Y_W  = 10;
    localparam int unsigned VEL_W    = 16;
    localparam int unsigned DIST_W   = 24;
    localparam int unsigned DIFF_W   = 12;
    localparam int unsigned SQ_W     = 22;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned PIPE_LAT = 2;

    localparam int unsigned BALL_THRESH = (BALL_RADIUS + PIN_RADIUS) * (BALL_RADIUS + PIN_RADIUS);
    localparam int unsigned PIN_THRESH  = (2 * PIN_RADIUS) * (2 * PIN_RADIUS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BALL  = 3'd1,
        PINS  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic {
        KIND_BALL = 1'b0,
        KIND_PIN  = 1'b1
    } pair_kind_t;

    // For ball checks i carries the pin index and j mirrors it.
    typedef struct packed {
        pair_kind_t       kind;
        logic [IDX_W-1:0] i;
        logic [IDX_W-1:0] j;
    } pair_tag_t;

    // A pin takes part in checks only while it is inside the visible screen.
    function automatic logic on_screen(input logic [POS_X_W-1:0] x, input logic [POS_Y_W-1:0] y);
        return (x < POS_X_W'(SCREEN_WIDTH)) && (y < POS_Y_W'(SCREEN_HEIGHT));
    endfunction

endpackage

// File: rtl/pair_check.sv
// Two-stage squared-distance compare shared by ball and pin phases.
module pair_check
    import physics_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               in_valid,
    input  pair_tag_t          in_tag,
    input  logic [POS_X_W-1:0] a_x,
    input  logic [POS_Y_W-1:0] a_y,
    input  logic [POS_X_W-1:0] b_x,
    input  logic [POS_Y_W-1:0] b_y,
    output logic               out_valid,
    output logic               out_hit,
    output pair_tag_t          out_tag
);

    logic signed [DIFF_W-1:0] dx_c, dy_c;
    logic signed [SQ_W-1:0]   dx_ext_c, dy_ext_c;
    logic [SQ_W-1:0]          dx2_d, dy2_d, dx2_q, dy2_q;
    logic                     v1_d, v1_q;
    pair_tag_t                tag1_d, tag1_q;
    logic [DIST_W-1:0]        sum_c;
    logic [DIST_W-1:0]        thr_c;
    logic                     v2_d, v2_q, hit2_d, hit2_q;
    pair_tag_t                tag2_d, tag2_q;

    // Stage 1: signed differences and their squares.
    always_comb begin
        dx_c     = $signed(DIFF_W'(a_x)) - $signed(DIFF_W'(b_x));
        dy_c     = $signed(DIFF_W'(a_y)) - $signed(DIFF_W'(b_y));
        dx_ext_c = SQ_W'(dx_c);
        dy_ext_c = SQ_W'(dy_c);
        dx2_d    = SQ_W'(dx_ext_c * dx_ext_c);
        dy2_d    = SQ_W'(dy_ext_c * dy_ext_c);
        v1_d     = in_valid;
        tag1_d   = in_tag;
    end

    // Stage 2: sum and compare against the kind-selected contact threshold.
    always_comb begin
        sum_c  = DIST_W'(dx2_q) + DIST_W'(dy2_q);
        thr_c  = (tag1_q.kind == KIND_BALL) ? DIST_W'(BALL_THRESH) : DIST_W'(PIN_THRESH);
        v2_d   = v1_q;
        hit2_d = v1_q && (sum_c <= thr_c);
        tag2_d = tag1_q;
    end

    // Pipeline registers; only the valid bits need clearing on reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            hit2_q <= 1'b0;
            dx2_q  <= '0;
            dy2_q  <= '0;
            tag1_q <= '0;
            tag2_q <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            hit2_q <= hit2_d;
            dx2_q  <= dx2_d;
            dy2_q  <= dy2_d;
            tag1_q <= tag1_d;
            tag2_q <= tag2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_hit   = hit2_q;
    assign out_tag   = tag2_q;

endmodule

// File: rtl/collision_scheduler.sv
// Sequences ball-vs-pin then pin-vs-pin checks through one shared pair_check per frame.
module collision_scheduler
    import physics_pkg::*;
(
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               start_in,
    input  logic [POS_X_W-1:0]                 ball_x,
    input  logic [POS_Y_W-1:0]                 ball_y,
    input  logic [VEL_W-1:0]                   ball_vx_in,
    input  logic [VEL_W-1:0]                   ball_vy_in,
    input  logic [NUM_PINS-1:0][POS_X_W-1:0]   pins_x,
    input  logic [NUM_PINS-1:0][POS_Y_W-1:0]   pins_y,
    input  logic [NUM_PINS-1:0][VEL_W-1:0]     pins_vx_in,
    input  logic [NUM_PINS-1:0][VEL_W-1:0]     pins_vy_in,
    output logic [NUM_PINS-1:0][VEL_W-1:0]     pins_vx_out,
    output logic [NUM_PINS-1:0][VEL_W-1:0]     pins_vy_out,
    output logic [NUM_PINS-1:0]                pins_hit,
    output logic                               busy,
    output logic                               done
);

    state_t                            state_d, state_q;
    logic [IDX_W-1:0]                  cnt_d, cnt_q;
    logic [IDX_W-1:0]                  pi_d, pi_q, pj_d, pj_q;

    logic [POS_X_W-1:0]                snap_bx_d, snap_bx_q;
    logic [POS_Y_W-1:0]                snap_by_d, snap_by_q;
    logic [VEL_W-1:0]                  snap_bvx_d, snap_bvx_q, snap_bvy_d, snap_bvy_q;
    logic [NUM_PINS-1:0][POS_X_W-1:0]  snap_px_d, snap_px_q;
    logic [NUM_PINS-1:0][POS_Y_W-1:0]  snap_py_d, snap_py_q;
    logic [NUM_PINS-1:0][VEL_W-1:0]    snap_pvx_d, snap_pvx_q, snap_pvy_d, snap_pvy_q;

    logic [NUM_PINS-1:0][VEL_W-1:0]    wvx_d, wvx_q, wvy_d, wvy_q;
    logic [NUM_PINS-1:0]               whit_d, whit_q;
    logic [NUM_PINS-1:0][VEL_W-1:0]    vx_out_d, vx_out_q, vy_out_d, vy_out_q;
    logic [NUM_PINS-1:0]               hit_out_d, hit_out_q;
    logic                              busy_d, busy_q, done_d, done_q;

    logic                              iss_valid_c;
    pair_tag_t                         iss_tag_c;
    logic [POS_X_W-1:0]                iss_ax_c, iss_bx_c;
    logic [POS_Y_W-1:0]                iss_ay_c, iss_by_c;
    logic                              res_valid, res_hit;
    pair_tag_t                         res_tag;

    // Issue mux: one pair per cycle from the snapshot, suppressed when a pin is off-screen.
    always_comb begin
        iss_valid_c = 1'b0;
        iss_tag_c   = '0;
        iss_ax_c    = snap_bx_q;
        iss_ay_c    = snap_by_q;
        iss_bx_c    = '0;
        iss_by_c    = '0;
        case (state_q)
            BALL: begin
                iss_valid_c    = on_screen(snap_px_q[cnt_q], snap_py_q[cnt_q]);
                iss_tag_c.kind = KIND_BALL;
                iss_tag_c.i    = cnt_q;
                iss_tag_c.j    = cnt_q;
                iss_bx_c       = snap_px_q[cnt_q];
                iss_by_c       = snap_py_q[cnt_q];
            end
            PINS: begin
                iss_valid_c    = on_screen(snap_px_q[pi_q], snap_py_q[pi_q])
                              && on_screen(snap_px_q[pj_q], snap_py_q[pj_q]);
                iss_tag_c.kind = KIND_PIN;
                iss_tag_c.i    = pi_q;
                iss_tag_c.j    = pj_q;
                iss_ax_c       = snap_px_q[pi_q];
                iss_ay_c       = snap_py_q[pi_q];
                iss_bx_c       = snap_px_q[pj_q];
                iss_by_c       = snap_py_q[pj_q];
            end
            default: ;
        endcase
    end

    pair_check u_pair_check (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .in_valid  (iss_valid_c),
        .in_tag    (iss_tag_c),
        .a_x       (iss_ax_c),
        .a_y       (iss_ay_c),
        .b_x       (iss_bx_c),
        .b_y       (iss_by_c),
        .out_valid (res_valid),
        .out_hit   (res_hit),
        .out_tag   (res_tag)
    );

    // Next state: apply returning results first so the final copy sees the last write.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pi_d       = pi_q;
        pj_d       = pj_q;
        snap_bx_d  = snap_bx_q;
        snap_by_d  = snap_by_q;
        snap_bvx_d = snap_bvx_q;
        snap_bvy_d = snap_bvy_q;
        snap_px_d  = snap_px_q;
        snap_py_d  = snap_py_q;
        snap_pvx_d = snap_pvx_q;
        snap_pvy_d = snap_pvy_q;
        wvx_d      = wvx_q;
        wvy_d      = wvy_q;
        whit_d     = whit_q;
        vx_out_d   = vx_out_q;
        vy_out_d   = vy_out_q;
        hit_out_d  = hit_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (res_valid && res_hit) begin
            if (res_tag.kind == KIND_BALL) begin
                wvx_d[res_tag.i]  = snap_bvx_q;
                wvy_d[res_tag.i]  = snap_bvy_q;
                whit_d[res_tag.i] = 1'b1;
            end else begin
                wvx_d[res_tag.i]  = snap_pvx_q[res_tag.j];
                wvy_d[res_tag.i]  = snap_pvy_q[res_tag.j];
                wvx_d[res_tag.j]  = snap_pvx_q[res_tag.i];
                wvy_d[res_tag.j]  = snap_pvy_q[res_tag.i];
                whit_d[res_tag.i] = 1'b1;
                whit_d[res_tag.j] = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    snap_bx_d  = ball_x;
                    snap_by_d  = ball_y;
                    snap_bvx_d = ball_vx_in;
                    snap_bvy_d = ball_vy_in;
                    snap_px_d  = pins_x;
                    snap_py_d  = pins_y;
                    snap_pvx_d = pins_vx_in;
                    snap_pvy_d = pins_vy_in;
                    wvx_d      = pins_vx_in;
                    wvy_d      = pins_vy_in;
                    whit_d     = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = BALL;
                end
            end
            BALL: begin
                if (cnt_q == IDX_W'(NUM_PINS - 1)) begin
                    cnt_d   = '0;
                    pi_d    = '0;
                    pj_d    = IDX_W'(1);
                    state_d = PINS;
                end else begin
                    cnt_d = IDX_W'(cnt_q + IDX_W'(1));
                end
            end
            PINS: begin
                if (pj_q == IDX_W'(NUM_PINS - 1)) begin
                    if (pi_q == IDX_W'(NUM_PINS - 2)) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        pi_d = IDX_W'(pi_q + IDX_W'(1));
                        pj_d = IDX_W'(pi_q + IDX_W'(2));
                    end
                end else begin
                    pj_d = IDX_W'(pj_q + IDX_W'(1));
                end
            end
            DRAIN: begin
                if (cnt_q == IDX_W'(PIPE_LAT - 1)) begin
                    vx_out_d  = wvx_d;
                    vy_out_d  = wvy_d;
                    hit_out_d = whit_d;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = DONE;
                end else begin
                    cnt_d = IDX_W'(cnt_q + IDX_W'(1));
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pi_q       <= '0;
            pj_q       <= '0;
            snap_bx_q  <= '0;
            snap_by_q  <= '0;
            snap_bvx_q <= '0;
            snap_bvy_q <= '0;
            snap_px_q  <= '0;
            snap_py_q  <= '0;
            snap_pvx_q <= '0;
            snap_pvy_q <= '0;
            wvx_q      <= '0;
            wvy_q      <= '0;
            whit_q     <= '0;
            vx_out_q   <= '0;
            vy_out_q   <= '0;
            hit_out_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pi_q       <= pi_d;
            pj_q       <= pj_d;
            snap_bx_q  <= snap_bx_d;
            snap_by_q  <= snap_by_d;
            snap_bvx_q <= snap_bvx_d;
            snap_bvy_q <= snap_bvy_d;
            snap_px_q  <= snap_px_d;
            snap_py_q  <= snap_py_d;
            snap_pvx_q <= snap_pvx_d;
            snap_pvy_q <= snap_pvy_d;
            wvx_q      <= wvx_d;
            wvy_q      <= wvy_d;
            whit_q     <= whit_d;
            vx_out_q   <= vx_out_d;
            vy_out_q   <= vy_out_d;
            hit_out_q  <= hit_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign pins_vx_out = vx_out_q;
    assign pins_vy_out = vy_out_q;
    assign pins_hit    = hit_out_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
